// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load/issue stages and the register-file write-port arbiter.
// The master drives requests and issue info; the slave (arbiter) returns ready, write port and scoreboard.
interface regfile_wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] busy;
    logic        idle;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output issue_valid, issue_rd,
        input  alu_ready, ld_ready,
        input  we3, a3, wd3, busy, idle
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  issue_valid, issue_rd,
        output alu_ready, ld_ready,
        output we3, a3, wd3, busy, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter + busy scoreboard for the register file's single write port (a3/we3/wd3).
// Latency: push at edge N, earliest registered write-port output after edge N+1; one write per cycle.
// Backpressure: per-source ready = FIFO not full (no ready-through-pop). WB_ARB_LOAD_PRIO_EN gives load fixed priority.

module fifo_sync #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty    = (wptr == rptr);
    assign head_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int QDEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    localparam int EW = $bits(wb_entry_t);

    wb_entry_t   alu_in;
    wb_entry_t   ld_in;
    wb_entry_t   alu_head;
    wb_entry_t   ld_head;
    logic        alu_full;
    logic        alu_empty;
    logic        ld_full;
    logic        ld_empty;
    logic        grant_alu;
    logic        grant_ld;
    logic        last_grant;
    logic        we3_q;
    logic [4:0]  a3_q;
    logic [31:0] wd3_q;
    logic [31:0] busy_q;
    logic [31:0] busy_next;
    wb_entry_t   win;

    assign alu_in = '{rd: bus.alu_rd, data: bus.alu_data};
    assign ld_in  = '{rd: bus.ld_rd,  data: bus.ld_data};

    fifo_sync #(.W(EW), .DEPTH(QDEPTH)) u_alu_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (bus.alu_valid),
        .push_dat (alu_in),
        .pop      (grant_alu),
        .head_dat (alu_head),
        .full     (alu_full),
        .empty    (alu_empty)
    );

    fifo_sync #(.W(EW), .DEPTH(QDEPTH)) u_ld_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (bus.ld_valid),
        .push_dat (ld_in),
        .pop      (grant_ld),
        .head_dat (ld_head),
        .full     (ld_full),
        .empty    (ld_empty)
    );

    always_comb begin
        grant_ld  = 1'b0;
        grant_alu = 1'b0;
`ifdef WB_ARB_LOAD_PRIO_EN
        grant_ld  = !ld_empty;
`else
        // On a tie, the source not granted last time wins.
        grant_ld  = !ld_empty && (alu_empty || !last_grant);
`endif
        grant_alu = !alu_empty && !grant_ld;
        win       = grant_ld ? ld_head : alu_head;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            we3_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
        end else if (grant_alu || grant_ld) begin
            last_grant <= grant_ld;
            we3_q      <= (win.rd != 5'd0);
            a3_q       <= win.rd;
            wd3_q      <= win.data;
        end else begin
            we3_q      <= 1'b0;
        end
    end

    // Set is applied after clear so a re-issue on the retiring edge keeps the bit.
    always_comb begin
        busy_next = busy_q;
        if (we3_q) begin
            busy_next[a3_q] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign bus.alu_ready = !alu_full;
    assign bus.ld_ready  = !ld_full;
    assign bus.we3       = we3_q;
    assign bus.a3        = a3_q;
    assign bus.wd3       = wd3_q;
    assign bus.busy      = busy_q;
    assign bus.idle      = alu_empty && ld_empty && !we3_q;
endmodule
